// File: rtl/sa_pkg.sv
// Shared systolic-array types: result width, tagged result record and index-width helper.
package sa_pkg;

  localparam int SA_D_W = 8;
  localparam int SA_N   = 4;
  localparam int RES_W  = 2 * SA_D_W;

  // Width of a position-within-tile field; at least one bit even for tiny tiles.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                      last;
    logic [idx_w(SA_N)-1:0]    index;
    logic [RES_W-1:0]          data;
  } sa_result_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head entry; a push is visible at the output one edge later.
// Push into a full FIFO is accepted only alongside a pop; there is no empty-FIFO bypass.
module sync_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_nxt;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = head_q;
  assign rd_nxt  = rd_ptr_q + AW'(1);

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_nxt : rd_ptr_q;
    level_d  = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LW'(1);
    end
    // The head register mirrors the entry at the read pointer after this edge.
    head_d = head_q;
    if (do_pop) begin
      if (level_q == LW'(1)) begin
        if (do_push) begin
          head_d = wdata_i;
        end
      end else begin
        head_d = mem_q[rd_nxt];
      end
    end else if (empty_o && do_push) begin
      head_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Buffers one systolic row's never-stalling result chain, tagging tile position and flagging drops (sticky).
// One-edge push-to-output latency; RESULT_COLLECTOR_SAT_EN clamps stored results to D_W bits.
module result_collector
  import sa_pkg::*;
#(
  parameter int D_W   = 8,
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*D_W-1:0]         in_data,
  input  logic                     in_valid,
  output logic [2*D_W-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(N)-1:0]     m_index,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int RW = 2 * D_W;
  localparam int IW = idx_w(N);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic          last;
    logic [IW-1:0] index;
    logic [RW-1:0] data;
  } entry_t;

  entry_t        wr_entry, head;
  logic [RW-1:0] store_data;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, push, pop, drop;
  logic [LW-1:0] fifo_level;

`ifdef RESULT_COLLECTOR_SAT_EN
  assign store_data = (|in_data[RW-1:D_W]) ? {{D_W{1'b0}}, {D_W{1'b1}}} : in_data;
`else
  assign store_data = in_data;
`endif

  assign pop  = !empty && m_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && !push;

  always_comb begin
    wr_entry.data  = store_data;
    wr_entry.index = wr_idx_q;
    wr_entry.last  = (wr_idx_q == IW'(N-1));
    // Dropped beats still consume a tile slot so later beats stay aligned.
    wr_idx_d = wr_idx_q;
    if (in_valid) begin
      wr_idx_d = (wr_idx_q == IW'(N-1)) ? '0 : wr_idx_q + IW'(1);
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_idx_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_idx_q <= wr_idx_d;
      ovf_q    <= ovf_d;
    end
  end

  sync_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  assign m_data   = head.data;
  assign m_index  = head.index;
  assign m_last   = head.last;
  assign m_valid  = !empty;
  assign level    = fifo_level;
  assign overflow = ovf_q;

endmodule
